led_vu_driver: RTL and testbench

- Downstream consumer of the LED PIO's 8-bit out_port; turns the level the Nios writes into a VU-meter bar on the board's 8 LEDs.
- Bar behaviour: instant attack, timed decay, optional peak-hold dot, global PWM dimming.
- Sits between the PIO output and the LED pins, so firmware writes only a level byte per audio frame.

---
 rtl/led_vu_pkg.sv | 16 +
 rtl/led_vu_driver_if.sv | 25 ++
 rtl/led_vu_tick_gen.sv | 35 +++
 rtl/led_vu_driver.sv | 114 +++++++++++
 tb/tb_led_vu_driver.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/led_vu_pkg.sv
// Shared constants and the level-to-bar mapping for the LED VU meter driver.
package led_vu_pkg;

  localparam int LED_COUNT = 8;
  localparam int LEVEL_W   = 8;
  localparam int BAR_W     = 4;

  // Zero stays dark; any non-zero level lights at least one LED, 32 levels per LED.
  function automatic logic [BAR_W-1:0] level_to_bar(input logic [LEVEL_W-1:0] level);
    if (level == '0) begin
      return '0;
    end
    return BAR_W'(level[LEVEL_W-1 -: 3]) + BAR_W'(1);
  endfunction

endpackage

// File: rtl/led_vu_driver_if.sv
// Signal bundle between the LED PIO side and the VU meter driver.
// There is no handshake: level_in and brightness are sampled on every clock
// edge, and led_out/bar_level/peak_level are valid on every cycle.
interface led_vu_driver_if #(
  parameter int PWM_BITS = 4
);
  import led_vu_pkg::*;

  logic [LEVEL_W-1:0]   level_in;
  logic [PWM_BITS-1:0]  brightness;
  logic [LED_COUNT-1:0] led_out;
  logic [BAR_W-1:0]     bar_level;
  logic [BAR_W-1:0]     peak_level;

  modport master (
    output level_in, brightness,
    input  led_out, bar_level, peak_level
  );

  modport slave (
    input  level_in, brightness,
    output led_out, bar_level, peak_level
  );

endinterface

// File: rtl/led_vu_tick_gen.sv
// Decay prescaler: one-cycle tick every DECAY_DIV clocks, phase restarts on reset.
module led_vu_tick_gen #(
  parameter int DECAY_DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DECAY_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Next count: wrap to zero after the last phase.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_vu_driver.sv
// LED VU meter driver: instant attack, timed decay, PWM dimming of the bar.
// Optional peak-hold dot enabled by defining LED_VU_PEAK_HOLD_EN.
module led_vu_driver
  import led_vu_pkg::*;
#(
  parameter int DECAY_DIV  = 500000,
  parameter int HOLD_TICKS = 50,
  parameter int PWM_BITS   = 4
) (
  input  logic          clk,
  input  logic          reset,
  led_vu_driver_if.slave vu
);

  logic                 tick;
  logic [BAR_W-1:0]     target;
  logic [BAR_W-1:0]     bar_q, bar_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q;
  logic                 pwm_on;
  logic [LED_COUNT-1:0] led_q, led_d;

  led_vu_tick_gen #(
    .DECAY_DIV (DECAY_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  assign target = level_to_bar(vu.level_in);
  assign pwm_on = (&vu.brightness) || (pwm_cnt_q < vu.brightness);

  // Bar next state: attack beats a coincident tick, decay one step per tick.
  always_comb begin
    bar_d = bar_q;
    if (target > bar_q) begin
      bar_d = target;
    end else if (tick && (bar_q > target)) begin
      bar_d = bar_q - BAR_W'(1);
    end
  end

`ifdef LED_VU_PEAK_HOLD_EN
  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic [BAR_W-1:0]  peak_q, peak_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Peak next state: re-arm on a new peak, otherwise hold then fall toward the bar.
  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    if (target >= peak_q) begin
      peak_d = target;
      hold_d = HOLD_W'(HOLD_TICKS);
    end else if (tick) begin
      if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else if (peak_q > bar_q) begin
        peak_d = peak_q - BAR_W'(1);
      end
    end
  end

  // Peak and hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= '0;
      hold_q <= '0;
    end else begin
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  // LED pattern: bar plus peak dot, gated by PWM.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      led_d[i] = pwm_on && ((BAR_W'(i) < bar_q) ||
                 ((peak_q != '0) && (BAR_W'(i) == peak_q - BAR_W'(1))));
    end
  end

  assign vu.peak_level = peak_q;
`else
  // LED pattern: bar only, gated by PWM.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      led_d[i] = pwm_on && (BAR_W'(i) < bar_q);
    end
  end

  assign vu.peak_level = '0;
`endif

  // Bar, PWM counter and registered LED outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bar_q     <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      bar_q     <= bar_d;
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      led_q     <= led_d;
    end
  end

  assign vu.led_out   = led_q;
  assign vu.bar_level = bar_q;

endmodule

// File: tb/tb_led_vu_driver.sv
// Testbench for led_vu_driver: directed plan sequences plus randomized runs,
// checked each cycle against a behavioural model of the meter.
module tb_led_vu_driver;

  localparam int DIV  = 4;
  localparam int HOLD = 2;
  localparam int PMAX = 15;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  led_vu_driver_if #(.PWM_BITS(4)) vu ();

  led_vu_driver #(
    .DECAY_DIV  (DIV),
    .HOLD_TICKS (HOLD),
    .PWM_BITS   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vu    (vu)
  );

  // Scoreboard state.
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Reference model: meter state plus cycle phases since the last reset.
  int m_bar, m_peak, m_hold, m_phase, m_pwm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bar = 0; m_peak = 0; m_hold = 0; m_phase = 0; m_pwm = 0;
  endtask

  // Advance the model by one clock with the given inputs.
  task automatic model_step(input bit rst, input int lvl, input int bright);
    int  tgt, nb, np, nh, mask;
    bit  tick, on;
    if (rst) begin
      model_reset();
      exp_q.push_back(8'h00);
      return;
    end
    tgt  = (lvl == 0) ? 0 : (lvl / 32) + 1;
    tick = (m_phase == DIV - 1);
    on   = (bright == PMAX) || (m_pwm < bright);
    mask = (1 << m_bar) - 1;
    if (m_peak != 0) mask = mask | (1 << (m_peak - 1));
    exp_q.push_back(on ? mask[7:0] : 8'h00);
    nb = m_bar;
    if (tgt > m_bar) nb = tgt;
    else if (tick && m_bar > tgt) nb = m_bar - 1;
`ifdef LED_VU_PEAK_HOLD_EN
    np = m_peak; nh = m_hold;
    if (tgt >= m_peak) begin
      np = tgt; nh = HOLD;
    end else if (tick) begin
      if (m_hold != 0) nh = m_hold - 1;
      else if (m_peak > m_bar) np = m_peak - 1;
    end
`else
    np = 0; nh = 0;
`endif
    m_bar = nb; m_peak = np; m_hold = nh;
    m_phase = (m_phase + 1) % DIV;
    m_pwm = (m_pwm + 1) % 16;
  endtask

  // Driver: apply inputs, clock once, compare all outputs.
  task automatic step(input bit rst, input int lvl, input int bright);
    logic [7:0] e;
    reset = rst;
    vu.level_in = lvl[7:0];
    vu.brightness = bright[3:0];
    model_step(rst, lvl, bright);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("bar_level", 32'(vu.bar_level), 32'(m_bar));
    check("peak_level", 32'(vu.peak_level), 32'(m_peak));
    check("led_out", 32'(vu.led_out), 32'(e));
  endtask

  int lvl, br, run, cnt;
  int map_lvl[5] = '{8'h00, 8'h01, 8'h20, 8'h9F, 8'hE0};
  int map_bar[5] = '{0, 1, 2, 5, 8};
  int map_led[5] = '{8'h00, 8'h01, 8'h03, 8'h1F, 8'hFF};

  initial begin
    vu.level_in = 8'h00;
    vu.brightness = 4'hF;
    model_reset();

    // Reset with full level applied, then release.
    repeat (3) step(1'b1, 8'hFF, 15);
    check("reset_led", 32'(vu.led_out), 32'h00);
    step(1'b0, 8'hFF, 15);
    check("release_bar", 32'(vu.bar_level), 32'd8);
    step(1'b0, 8'hFF, 15);
    check("release_led", 32'(vu.led_out), 32'hFF);

    // Mapping examples, each from a fresh reset.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 0, 15);
      step(1'b0, map_lvl[k], 15);
      check("map_bar", 32'(vu.bar_level), 32'(map_bar[k]));
      step(1'b0, map_lvl[k], 15);
      check("map_led", 32'(vu.led_out), 32'(map_led[k]));
    end

    // Decay from full scale with peak hold.
    step(1'b1, 0, 15);
    repeat (2) step(1'b0, 8'hFF, 15);
    repeat (40) step(1'b0, 8'h00, 15);
    check("decay_end_bar", 32'(vu.bar_level), 32'd0);

    // Attack on a tick cycle beats the decrement.
    step(1'b1, 0, 15);
    step(1'b0, 8'h5F, 15);
    while (m_phase != DIV - 1) step(1'b0, 8'h5F, 15);
    check("attack_pre_bar", 32'(vu.bar_level), 32'd3);
    step(1'b0, 8'hA0, 15);
    check("attack_wins", 32'(vu.bar_level), 32'd6);

    // PWM duty at brightness 4, 0 and 15.
    step(1'b0, 8'hFF, 4);
    step(1'b0, 8'hFF, 4);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 8'hFF, 4);
      if (vu.led_out == 8'hFF) cnt++;
    end
    check("pwm_duty4", 32'(cnt), 32'd4);
    repeat (18) step(1'b0, 8'hFF, 0);
    repeat (18) step(1'b0, 8'hFF, 15);

    // Reset in the middle of a decay.
    repeat (2) step(1'b0, 8'hFF, 15);
    repeat (7) step(1'b0, 8'h00, 15);
    step(1'b1, 8'h00, 15);
    check("midreset_bar", 32'(vu.bar_level), 32'd0);
    repeat (10) step(1'b0, 8'hC0, 15);
    repeat (20) step(1'b0, 8'h00, 15);

    // Randomized segments: held levels, fast changes, brightness and resets.
    for (int s = 0; s < 300; s++) begin
      lvl = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      br  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 15;
      run = $urandom_range(1, 20);
      for (int c = 0; c < run; c++) begin
        if ($urandom_range(0, 4) == 0) lvl = $urandom_range(0, 255);
        step(($urandom_range(0, 299) == 0), lvl, br);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
